// File: rtl/lifo_stack_if.sv
// Push/pop/replace request lines and registered stack status for lifo_stack.
interface lifo_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             PUSH;
    logic             POP;
    logic [WIDTH-1:0] DIN;
    logic             CLR_ERR;
    logic [WIDTH-1:0] DOUT;
    logic [CNT_W-1:0] COUNT;
    logic             EMPTY;
    logic             FULL;
    logic             OVF;
    logic             UNF;

    modport master (
        output PUSH, POP, DIN, CLR_ERR,
        input  DOUT, COUNT, EMPTY, FULL, OVF, UNF
    );

    modport slave (
        input  PUSH, POP, DIN, CLR_ERR,
        output DOUT, COUNT, EMPTY, FULL, OVF, UNF
    );
endinterface

// File: rtl/lifo_stack.sv
// LIFO stack with registered top-of-stack, occupancy count and sticky
// overflow/underflow flags; one push, pop or replace-top per clock.
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic       CLK,
    input  logic       RST,
    lifo_stack_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_en;
    logic [CNT_W-1:0] wr_idx;
    logic [CNT_W-1:0] top_idx, below_idx;
    logic             empty, full;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign top_idx   = count_q - CNT_W'(1);
    assign below_idx = count_q - CNT_W'(2);

    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        // New errors win over a same-cycle clear.
        ovf_d   = ovf_q & ~bus.CLR_ERR;
        unf_d   = unf_q & ~bus.CLR_ERR;
        wr_en   = 1'b0;
        wr_idx  = count_q;
        case ({bus.PUSH, bus.POP})
            2'b10: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    dout_d  = bus.DIN;
                end
            end
            2'b01: begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    count_d = top_idx;
                    dout_d  = (count_q >= CNT_W'(2)) ? mem[below_idx[IDX_W-1:0]] : '0;
                end
            end
            2'b11: begin
                // Replace-top on a non-empty stack, plain push when empty.
                wr_en  = 1'b1;
                dout_d = bus.DIN;
                if (empty) begin
                    count_d = CNT_W'(1);
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && wr_en)
            mem[wr_idx[IDX_W-1:0]] <= bus.DIN;
    end

    assign bus.DOUT  = dout_q;
    assign bus.COUNT = count_q;
    assign bus.EMPTY = empty;
    assign bus.FULL  = full;
    assign bus.OVF   = ovf_q;
    assign bus.UNF   = unf_q;
endmodule

// File: tb/tb_lifo_stack.sv
// Vector-table bench for lifo_stack (WIDTH=8, DEPTH=4) with an expected-result queue.
module tb_lifo_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct {
        logic             rst, push, pop, clr;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] dout;
        logic [CNT_W-1:0] cnt;
        logic             e, f, o, u;
    } vec_t;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] dout;
        logic [CNT_W-1:0] cnt;
        logic             e, f, o, u;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    lifo_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(logic rst, logic push, logic pop, logic clr, logic [7:0] din,
                                logic [7:0] dout, int cnt, logic e, logic f, logic o, logic u);
        vec_t v;
        v.rst = rst; v.push = push; v.pop = pop; v.clr = clr; v.din = din;
        v.dout = dout; v.cnt = CNT_W'(cnt); v.e = e; v.f = f; v.o = o; v.u = u;
        return v;
    endfunction

    // Drive one cycle, queue its expected result, then compare #1 after the edge.
    task automatic step(input int id, input vec_t v);
        exp_t x, g;
        RST = v.rst; bus.PUSH = v.push; bus.POP = v.pop; bus.CLR_ERR = v.clr; bus.DIN = v.din;
        x.id = id; x.dout = v.dout; x.cnt = v.cnt; x.e = v.e; x.f = v.f; x.o = v.o; x.u = v.u;
        sb_q.push_back(x);
        @(posedge CLK);
        #1;
        g = sb_q.pop_front();
        checks++;
        if (bus.DOUT !== g.dout || bus.COUNT !== g.cnt || bus.EMPTY !== g.e ||
            bus.FULL !== g.f || bus.OVF !== g.o || bus.UNF !== g.u) begin
            errors++;
            $display("FAIL step%0d: got dout=%h cnt=%0d e=%b f=%b o=%b u=%b, want dout=%h cnt=%0d e=%b f=%b o=%b u=%b",
                     g.id, bus.DOUT, bus.COUNT, bus.EMPTY, bus.FULL, bus.OVF, bus.UNF,
                     g.dout, g.cnt, g.e, g.f, g.o, g.u);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; bus.PUSH = 1'b0; bus.POP = 1'b0; bus.CLR_ERR = 1'b0; bus.DIN = '0;
        //           rst push pop clr din     dout  cnt e  f  o  u
        // reset with junk on the inputs
        vecs.push_back(mk(1, 1, 1, 1, 8'hFF, 8'h00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'hA5, 8'h00, 0, 1, 0, 0, 0));
        // fill
        vecs.push_back(mk(0, 1, 0, 0, 8'h11, 8'h11, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h22, 8'h22, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h33, 8'h33, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h44, 8'h44, 4, 0, 1, 0, 0));
        // overflow, clear, clear racing a new overflow
        vecs.push_back(mk(0, 1, 0, 0, 8'h55, 8'h44, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h44, 4, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h66, 8'h44, 4, 0, 1, 1, 0));
        // replace while full: no new error, ovf stays sticky
        vecs.push_back(mk(0, 1, 1, 0, 8'h77, 8'h77, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h77, 4, 0, 1, 0, 0));
        // drain
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h33, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h22, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h11, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
        // underflow, push+pop on empty acts as push
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 8'h9A, 8'h9A, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h9A, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
        // replace top on a two-deep stack
        vecs.push_back(mk(0, 1, 0, 0, 8'h11, 8'h11, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h22, 8'h22, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h77, 8'h77, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h11, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'hEE, 8'h00, 0, 1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            step(i, vecs[i]);

        // Reset in the middle of a sequence, with a push in the same cycle.
        step(100, mk(0, 1, 0, 0, 8'h01, 8'h01, 1, 0, 0, 0, 0));
        step(101, mk(0, 1, 0, 0, 8'h02, 8'h02, 2, 0, 0, 0, 0));
        step(102, mk(0, 1, 0, 0, 8'h03, 8'h03, 3, 0, 0, 0, 0));
        step(103, mk(1, 1, 0, 0, 8'h5A, 8'h00, 0, 1, 0, 0, 0));
        step(104, mk(0, 1, 0, 0, 8'hAB, 8'hAB, 1, 0, 0, 0, 0));
        step(105, mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));

        // Hold keeps data; push then pop back-to-back shows the older top.
        step(200, mk(0, 1, 0, 0, 8'hC3, 8'hC3, 1, 0, 0, 0, 0));
        step(201, mk(0, 0, 0, 0, 8'h3C, 8'hC3, 1, 0, 0, 0, 0));
        step(202, mk(0, 1, 0, 0, 8'h5E, 8'h5E, 2, 0, 0, 0, 0));
        step(203, mk(0, 0, 1, 0, 8'h00, 8'hC3, 1, 0, 0, 0, 0));
        step(204, mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
